fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, at least 2.
REQ-002 Parameter CNT_W, default 3, occupancy width; SHALL equal log2(DEPTH)+1.
REQ-003 CLK  input  1  clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-low.
REQ-005 FLUSH  input  1  synchronous queue clear (branch mispredict / redirect).
REQ-006 IN_VALID  input  1  fetch presents an entry.
REQ-007 IN_READY  output  1  queue accepts an entry this cycle.
REQ-008 Instr_IN  input  32  fetched instruction word.
REQ-009 PC_IN  input  32  instruction address.
REQ-010 PC_Plus4_IN  input  32  address of next sequential instruction.
REQ-011 Pred_taken_IN  input  1  branch predicted taken.
REQ-012 Pred_addr_IN  input  32  predicted target address.
REQ-013 Pred_state_IN  input  2  predictor counter state.
REQ-014 OUT_VALID  output  1  head entry valid for decode.
REQ-015 OUT_READY  input  1  decode consumes head (deasserted = decode stall).
REQ-016 Instr_OUT, PC_OUT, PC_Plus4_OUT, Pred_taken_OUT, Pred_addr_OUT, Pred_state_OUT  output  32/32/32/1/32/2  head entry fields.
REQ-017 COUNT  output  CNT_W  current occupancy, 0..DEPTH.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH entries, each holding all six payload fields, with head pointer, tail pointer and count registers.
REQ-019 Push SHALL occur when IN_VALID and IN_READY are both high; entry written at tail, tail advances by one modulo DEPTH.
REQ-020 Pop SHALL occur when OUT_VALID and OUT_READY are both high; head advances by one modulo DEPTH.
REQ-021 IN_READY SHALL be high exactly when COUNT is less than DEPTH; it SHALL NOT depend combinationally on OUT_READY.
REQ-022 OUT_VALID SHALL be high exactly when COUNT is nonzero.
REQ-023 Output fields SHALL reflect the head entry whenever OUT_VALID is high; when empty, all output fields SHALL be zero (bubble/NOP).
REQ-024 Latency: an entry pushed at edge N SHALL appear at the outputs after edge N (no same-cycle bypass when empty).
REQ-025 Simultaneous push and pop SHALL leave COUNT unchanged and preserve order; legal at any occupancy, including 1 and DEPTH-1.
REQ-026 When full (COUNT equals DEPTH), IN_VALID SHALL be ignored; a pop the same cycle frees a slot that becomes usable only on the next cycle.
REQ-027 Entries SHALL be delivered strictly in push order; pointer wrap-around SHALL not reorder or lose entries.
REQ-028 FLUSH high at an edge SHALL clear count, head and tail to zero; any push or pop in that cycle SHALL be discarded.
REQ-029 FLUSH SHALL take priority over push and pop; FLUSH held for several cycles SHALL keep the queue empty.
REQ-030 OUT_READY low SHALL hold the head entry and all outputs stable while pushes continue until full.

Reset
REQ-031 RESET low SHALL immediately, independent of CLK, clear count, head and tail to zero; OUT_VALID 0, IN_READY 1, COUNT 0, all output fields 0.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries; the first push after release SHALL appear as the head entry.
REQ-033 Payload storage contents need not be cleared by reset; outputs SHALL be zero regardless while empty.

Verification
REQ-034 Fill/drain: DEPTH=4, OUT_READY=0, push PC 0x00400000..0x0040000C -> COUNT 4, IN_READY 0; then OUT_READY=1 -> four pops in PC order, then OUT_VALID 0, outputs 0.
REQ-035 Wrap: continuous push and pop with OUT_READY=1 for 10 entries -> outputs trail inputs by one cycle, COUNT stays 1, order preserved across pointer wrap.
REQ-036 Full plus pop: COUNT 4, IN_VALID=1 with new entry, OUT_READY=1 -> head popped, new entry not accepted, COUNT 3; next cycle entry accepted, COUNT stays 3.
REQ-037 Flush: COUNT 3, FLUSH=1 with IN_VALID=1 and OUT_READY=1 -> next cycle COUNT 0, OUT_VALID 0, Instr_OUT 0; the discarded push never appears.
REQ-038 Async reset: RESET low between clock edges with COUNT 2 -> outputs and COUNT zero before the next edge; after release, push of Instr 0x8C010004 appears on Instr_OUT one cycle later.
REQ-039 Prediction fields: push Pred_taken=1, Pred_addr=0x00400040, Pred_state=2'b11 -> same values on outputs alongside matching PC and PC_Plus4.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular fetch queue between instruction fetch and decode
//
// Purpose:
//   Holds up to DEPTH fetched instructions, each with its PC, PC+4 and
//   branch prediction fields. Entries are handed to decode in fetch order.
//   FLUSH empties the queue on a redirect. The outputs read zero whenever
//   the queue is empty, so decode sees a bubble.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   CNT_W  occupancy width, log2(DEPTH)+1
//
// Ports:
//   CLK, RESET                clock; asynchronous active-low reset
//   FLUSH                     synchronous clear, overrides push and pop
//   IN_VALID / IN_READY       fetch-side handshake
//   Instr_IN, PC_IN, PC_Plus4_IN,
//   Pred_taken_IN, Pred_addr_IN, Pred_state_IN   entry payload
//   OUT_VALID / OUT_READY     decode-side handshake
//   Instr_OUT, PC_OUT, PC_Plus4_OUT,
//   Pred_taken_OUT, Pred_addr_OUT, Pred_state_OUT head entry payload
//   COUNT                     current occupancy, 0..DEPTH

module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,

  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      Instr_IN,
  input  logic [31:0]      PC_IN,
  input  logic [31:0]      PC_Plus4_IN,
  input  logic             Pred_taken_IN,
  input  logic [31:0]      Pred_addr_IN,
  input  logic [1:0]       Pred_state_IN,

  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      Instr_OUT,
  output logic [31:0]      PC_OUT,
  output logic [31:0]      PC_Plus4_OUT,
  output logic             Pred_taken_OUT,
  output logic [31:0]      Pred_addr_OUT,
  output logic [1:0]       Pred_state_OUT,

  output logic [CNT_W-1:0] COUNT
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pred_taken;
    logic [31:0] pred_addr;
    logic [1:0]  pred_state;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  entry_t           w_in_entry;
  entry_t           w_head_entry;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;

  // Ready/valid come from the registered count only, so IN_READY never
  // depends on OUT_READY and a slot freed by a pop is usable next cycle.
  assign w_in_ready  = (r_count < CNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);

  assign w_push = IN_VALID && w_in_ready;
  assign w_pop  = w_out_valid && OUT_READY;

  assign w_in_entry.instr      = Instr_IN;
  assign w_in_entry.pc         = PC_IN;
  assign w_in_entry.pc_plus4   = PC_Plus4_IN;
  assign w_in_entry.pred_taken = Pred_taken_IN;
  assign w_in_entry.pred_addr  = Pred_addr_IN;
  assign w_in_entry.pred_state = Pred_state_IN;

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (FLUSH) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is left unreset; the output mask hides stale data.
  always_ff @(posedge CLK) begin
    if (w_push && !FLUSH) begin
      r_mem[r_tail] <= w_in_entry;
    end
  end

  assign w_head_entry = r_mem[r_head];

  always_comb begin
    Instr_OUT      = '0;
    PC_OUT         = '0;
    PC_Plus4_OUT   = '0;
    Pred_taken_OUT = 1'b0;
    Pred_addr_OUT  = '0;
    Pred_state_OUT = '0;
    if (w_out_valid) begin
      Instr_OUT      = w_head_entry.instr;
      PC_OUT         = w_head_entry.pc;
      PC_Plus4_OUT   = w_head_entry.pc_plus4;
      Pred_taken_OUT = w_head_entry.pred_taken;
      Pred_addr_OUT  = w_head_entry.pred_addr;
      Pred_state_OUT = w_head_entry.pred_state;
    end
  end

  assign IN_READY  = w_in_ready;
  assign OUT_VALID = w_out_valid;
  assign COUNT     = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue

module tb_fetch_queue;

  logic        CLK;
  logic        RESET;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] Instr_IN;
  logic [31:0] PC_IN;
  logic [31:0] PC_Plus4_IN;
  logic        Pred_taken_IN;
  logic [31:0] Pred_addr_IN;
  logic [1:0]  Pred_state_IN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] Instr_OUT;
  logic [31:0] PC_OUT;
  logic [31:0] PC_Plus4_OUT;
  logic        Pred_taken_OUT;
  logic [31:0] Pred_addr_OUT;
  logic [1:0]  Pred_state_OUT;
  logic [2:0]  COUNT;

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .FLUSH          (FLUSH),
    .IN_VALID       (IN_VALID),
    .IN_READY       (IN_READY),
    .Instr_IN       (Instr_IN),
    .PC_IN          (PC_IN),
    .PC_Plus4_IN    (PC_Plus4_IN),
    .Pred_taken_IN  (Pred_taken_IN),
    .Pred_addr_IN   (Pred_addr_IN),
    .Pred_state_IN  (Pred_state_IN),
    .OUT_VALID      (OUT_VALID),
    .OUT_READY      (OUT_READY),
    .Instr_OUT      (Instr_OUT),
    .PC_OUT         (PC_OUT),
    .PC_Plus4_OUT   (PC_Plus4_OUT),
    .Pred_taken_OUT (Pred_taken_OUT),
    .Pred_addr_OUT  (Pred_addr_OUT),
    .Pred_state_OUT (Pred_state_OUT),
    .COUNT          (COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Payload fields derived from the PC so every entry is distinguishable.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h2000_0000 ^ pc;
  endfunction

  task automatic drive_pc(input logic [31:0] pc);
    IN_VALID      = 1'b1;
    Instr_IN      = instr_of(pc);
    PC_IN         = pc;
    PC_Plus4_IN   = pc + 32'd4;
    Pred_taken_IN = pc[2];
    Pred_addr_IN  = pc + 32'h100;
    Pred_state_IN = pc[3:2];
  endtask

  task automatic idle_in();
    IN_VALID      = 1'b0;
    Instr_IN      = 32'hDEAD_BEEF;
    PC_IN         = 32'hFFFF_FFF0;
    PC_Plus4_IN   = 32'hFFFF_FFF4;
    Pred_taken_IN = 1'b1;
    Pred_addr_IN  = 32'hFFFF_FFFF;
    Pred_state_IN = 2'b11;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, 64'(OUT_VALID), 64'd1);
    check({tag, ".pc"}, 64'(PC_OUT), 64'(pc));
    check({tag, ".instr"}, 64'(Instr_OUT), 64'(instr_of(pc)));
    check({tag, ".pc4"}, 64'(PC_Plus4_OUT), 64'(pc + 32'd4));
    check({tag, ".ptaken"}, 64'(Pred_taken_OUT), 64'(pc[2]));
    check({tag, ".paddr"}, 64'(Pred_addr_OUT), 64'(pc + 32'h100));
    check({tag, ".pstate"}, 64'(Pred_state_OUT), 64'(pc[3:2]));
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".valid"}, 64'(OUT_VALID), 64'd0);
    check({tag, ".count"}, 64'(COUNT), 64'd0);
    check({tag, ".ready"}, 64'(IN_READY), 64'd1);
    check({tag, ".instr"}, 64'(Instr_OUT), 64'd0);
    check({tag, ".pc"}, 64'(PC_OUT), 64'd0);
    check({tag, ".pc4"}, 64'(PC_Plus4_OUT), 64'd0);
    check({tag, ".ptaken"}, 64'(Pred_taken_OUT), 64'd0);
    check({tag, ".paddr"}, 64'(Pred_addr_OUT), 64'd0);
    check({tag, ".pstate"}, 64'(Pred_state_OUT), 64'd0);
  endtask

  initial begin
    RESET     = 1'b0;
    FLUSH     = 1'b0;
    OUT_READY = 1'b0;
    idle_in();

    // Reset state
    @(negedge CLK);
    check_empty("reset");
    @(negedge CLK);
    RESET = 1'b1;

    // Fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive_pc(32'h0040_0000 + 32'(i * 4));
      @(negedge CLK);
      check($sformatf("fill%0d.count", i), 64'(COUNT), 64'(i + 1));
      check_head($sformatf("fill%0d.head", i), 32'h0040_0000);
    end
    check("full.ready", 64'(IN_READY), 64'd0);
    drive_pc(32'h0040_0010);
    @(negedge CLK);
    check("full_ignore.count", 64'(COUNT), 64'd4);
    check_head("full_ignore.head", 32'h0040_0000);

    // Drain in push order
    idle_in();
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("drain%0d", i), 32'h0040_0000 + 32'(i * 4));
      @(negedge CLK);
    end
    check_empty("drained");

    // Streaming through the pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive_pc(32'h0041_0000 + 32'(i * 4));
      @(negedge CLK);
      check($sformatf("wrap%0d.count", i), 64'(COUNT), 64'd1);
      check_head($sformatf("wrap%0d", i), 32'h0041_0000 + 32'(i * 4));
    end
    idle_in();
    @(negedge CLK);
    check_empty("wrap_end");

    // Full with simultaneous pop: new entry waits one cycle
    OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_pc(32'h0042_0000 + 32'(i * 4));
      @(negedge CLK);
    end
    check("fp.count_full", 64'(COUNT), 64'd4);
    drive_pc(32'h0042_0010);
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("fp.count_after_pop", 64'(COUNT), 64'd3);
    check("fp.ready", 64'(IN_READY), 64'd1);
    check_head("fp.head1", 32'h0042_0004);
    @(negedge CLK);
    check("fp.count_pushpop", 64'(COUNT), 64'd3);
    check_head("fp.head2", 32'h0042_0008);
    idle_in();
    for (int i = 0; i < 3; i++) begin
      check_head($sformatf("fp.drain%0d", i), 32'h0042_0008 + 32'(i * 4));
      @(negedge CLK);
    end
    check_empty("fp.empty");

    // Flush beats a concurrent push and pop, and holds the queue empty
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_pc(32'h0043_0000 + 32'(i * 4));
      @(negedge CLK);
    end
    check("fl.count3", 64'(COUNT), 64'd3);
    FLUSH = 1'b1;
    OUT_READY = 1'b1;
    drive_pc(32'h0043_000C);
    @(negedge CLK);
    check_empty("fl.cycle1");
    @(negedge CLK);
    check_empty("fl.cycle2");
    FLUSH = 1'b0;
    OUT_READY = 1'b0;
    drive_pc(32'h0044_0000);
    @(negedge CLK);
    check("fl.count_after", 64'(COUNT), 64'd1);
    check_head("fl.newhead", 32'h0044_0000);
    idle_in();
    OUT_READY = 1'b1;
    @(negedge CLK);
    check_empty("fl.drained");

    // Asynchronous reset mid-operation
    OUT_READY = 1'b0;
    drive_pc(32'h0045_0000);
    @(negedge CLK);
    drive_pc(32'h0045_0004);
    @(negedge CLK);
    check("ar.count2", 64'(COUNT), 64'd2);
    idle_in();
    #2;
    RESET = 1'b0;
    #1;
    check_empty("ar.async");
    @(negedge CLK);
    check_empty("ar.held");
    RESET = 1'b1;
    IN_VALID      = 1'b1;
    Instr_IN      = 32'h8C01_0004;
    PC_IN         = 32'h0040_0020;
    PC_Plus4_IN   = 32'h0040_0024;
    Pred_taken_IN = 1'b0;
    Pred_addr_IN  = 32'h0;
    Pred_state_IN = 2'b01;
    @(negedge CLK);
    idle_in();
    check("ar.count1", 64'(COUNT), 64'd1);
    check("ar.instr", 64'(Instr_OUT), 64'h8C01_0004);
    check("ar.pc", 64'(PC_OUT), 64'h0040_0020);
    OUT_READY = 1'b1;
    @(negedge CLK);
    check_empty("ar.drained");

    // Prediction fields travel with their PC
    OUT_READY     = 1'b0;
    IN_VALID      = 1'b1;
    Instr_IN      = 32'h1000_FFFF;
    PC_IN         = 32'h0040_0030;
    PC_Plus4_IN   = 32'h0040_0034;
    Pred_taken_IN = 1'b1;
    Pred_addr_IN  = 32'h0040_0040;
    Pred_state_IN = 2'b11;
    @(negedge CLK);
    idle_in();
    check("pred.taken", 64'(Pred_taken_OUT), 64'd1);
    check("pred.addr", 64'(Pred_addr_OUT), 64'h0040_0040);
    check("pred.state", 64'(Pred_state_OUT), 64'd3);
    check("pred.pc", 64'(PC_OUT), 64'h0040_0030);
    check("pred.pc4", 64'(PC_Plus4_OUT), 64'h0040_0034);
    check("pred.instr", 64'(Instr_OUT), 64'h1000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
